opb_register_simulink2ppc: RTL and testbench
============================================

OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameters: C_BASEADDR, 32'h01094200, first byte address; C_HIGHADDR, 32'h010942FF, last byte address; C_OPB_AWIDTH, 32, address width; C_OPB_DWIDTH, 32, data width; C_FAMILY, "virtex5", target family.
REQ-002 SHALL have ports: OPB_Clk  in  1  single clock, also the user-side clock; OPB_Rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: OPB_ABus  in  [0:31]  address; OPB_BE  in  [0:3]  byte enables; OPB_DBus  in  [0:31]  write data; OPB_RNW  in  1  1 = read; OPB_select  in  1  transfer request; OPB_seqAddr  in  1  ignored.
REQ-004 SHALL have ports: Sl_DBus  out  [0:31]  read data; Sl_xferAck  out  1  transfer ack; Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
REQ-005 SHALL have ports: user_data_in  in  [31:0]  fabric value; user_valid  in  1  capture strobe.

Function
REQ-006 SHALL decode a hit when OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; OPB_ABus[29] selects word: 0 = DATA (offset 0x0), 1 = STATUS (offset 0x4).
REQ-007 SHALL capture user_data_in into a 32-bit holding register on every OPB_Clk edge where user_valid=1.
REQ-008 SHALL, on capture, set sticky NEW and increment a 16-bit capture counter that wraps 0xFFFF -> 0x0000.
REQ-009 SHALL return STATUS as: value bits [31:16] = capture counter, bit 1 = OVERRUN, bit 0 = NEW, all other bits 0.
REQ-010 SHALL implement handshake FSM IDLE -> ACK -> HOLD: IDLE->ACK on hit; ACK->HOLD unconditionally; HOLD->IDLE when OPB_select=0; HOLD->HOLD otherwise.
REQ-011 SHALL assert Sl_xferAck for exactly one cycle, only in ACK; read latency is one cycle from first hit cycle.
REQ-012 SHALL drive Sl_DBus with the selected word during ACK when OPB_RNW=1, and 0 in every other cycle.
REQ-013 SHALL register the read word at the IDLE->ACK transition so Sl_DBus is stable for the whole ACK cycle.
REQ-014 SHALL clear NEW in the ACK cycle of a DATA read.
REQ-015 SHALL keep NEW=1 when capture and DATA-read clear coincide (capture wins); the read returns the pre-capture value.
REQ-016 SHALL acknowledge writes to either word; DATA writes have no effect.
REQ-017 SHALL, on STATUS write with OPB_BE[3]=1 and OPB_DBus[30]=1, clear OVERRUN; all other STATUS bits are read-only.
REQ-018 SHALL ignore non-hit addresses: no ack, FSM stays IDLE.

Reset
REQ-019 SHALL, when OPB_Rst=0 at an OPB_Clk edge, clear holding register, NEW, OVERRUN and counter, and set FSM to IDLE.
REQ-020 SHALL hold Sl_xferAck=0 and Sl_DBus=0 in the cycle after reset; reset mid-transfer abandons it without ack.
REQ-021 SHALL ignore user_valid while OPB_Rst=0.

Configuration
REQ-022 SHALL, with OPB_S2P_OVERRUN_EN defined, set OVERRUN when a capture occurs while NEW=1 and no same-cycle DATA-read clear occurs; OVERRUN is cleared only per REQ-017 or reset.
REQ-023 SHALL, without OPB_S2P_OVERRUN_EN, omit the OVERRUN logic; STATUS bit 1 reads 0 and REQ-017 writes have no effect.

Verification
REQ-024 Reset, then read STATUS at 0x01094204 -> Sl_xferAck one cycle later, data 0x00000000.
REQ-025 user_valid pulse with user_data_in=0xDEADBEEF, read DATA at 0x01094200 -> 0xDEADBEEF; STATUS read -> 0x00010000 (NEW cleared).
REQ-026 Two captures (0x1, 0x2) without intervening read, then read STATUS -> 0x00020003 with macro, 0x00020001 without; write 0x2, BE=0xF to STATUS -> next STATUS read 0x00020001.
REQ-027 user_valid asserted in the same cycle as the DATA-read ACK -> returned value is the old data, NEW remains 1, OVERRUN unchanged.
REQ-028 Hold OPB_select=1 for 5 cycles -> exactly one Sl_xferAck pulse; read at 0x01094300 -> no ack; 65536 captures -> counter field reads 0x0000.

Source files
------------

// File: rtl/opb_register_simulink2ppc_if.sv
// opb_register_simulink2ppc_if: OPB slave-side bus bundle (big-endian bit numbering).
interface opb_register_simulink2ppc_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc.sv
// opb_register_simulink2ppc: fabric-to-PPC capture register on OPB; OPB_S2P_OVERRUN_EN adds the OVERRUN flag.
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01094200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010942FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst,
  opb_register_simulink2ppc_if.slave        opb,
  input  logic [31:0]                       user_data_in,
  input  logic                              user_valid
);
  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
  state_t                  state;
  logic [C_OPB_AWIDTH-1:0] abus;
  logic [C_OPB_DWIDTH-1:0] hold_reg, dbus_q, status, rd_word;
  logic [15:0]             cnt;
  logic                    new_flag, overrun, rd_clr, ack_q, hit, start, clr_new, unused_ok;
  assign abus    = opb.OPB_ABus;
  assign hit     = opb.OPB_select && abus >= C_BASEADDR && abus <= C_HIGHADDR;
  assign start   = state == IDLE && hit;
  assign clr_new = state == ACK && rd_clr;
  assign status  = {cnt, 14'd0, overrun, new_flag};
  assign rd_word = opb.OPB_ABus[29] ? status : hold_reg;
  assign opb.Sl_DBus    = dbus_q;
  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_BE, opb.OPB_DBus, C_FAMILY};
  // read word is latched on the hit edge, so a capture during ACK cannot disturb it
  always_ff @(posedge OPB_Clk)
    if (!OPB_Rst) begin
      state    <= IDLE;
      hold_reg <= '0;
      cnt      <= '0;
      new_flag <= 1'b0;
      rd_clr   <= 1'b0;
      ack_q    <= 1'b0;
      dbus_q   <= '0;
    end else begin
      if (user_valid) hold_reg <= user_data_in;
      cnt      <= cnt + 16'(user_valid);
      new_flag <= user_valid || (new_flag && !clr_new);
      rd_clr   <= start && opb.OPB_RNW && !opb.OPB_ABus[29];
      ack_q    <= start;
      dbus_q   <= start && opb.OPB_RNW ? rd_word : '0;
      state    <= state == IDLE ? (hit ? ACK : IDLE) : state == ACK ? HOLD : opb.OPB_select ? HOLD : IDLE;
    end
`ifdef OPB_S2P_OVERRUN_EN
  logic ovr_clr;
  always_ff @(posedge OPB_Clk)
    if (!OPB_Rst) begin
      overrun <= 1'b0;
      ovr_clr <= 1'b0;
    end else begin
      ovr_clr <= start && !opb.OPB_RNW && opb.OPB_ABus[29] && opb.OPB_BE[3] && opb.OPB_DBus[30];
      overrun <= (user_valid && new_flag && !clr_new) || (overrun && !(state == ACK && ovr_clr));
    end
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// tb_opb_register_simulink2ppc: vector-table and corner-sequence checks of the OPB capture register.
module tb_opb_register_simulink2ppc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] user_data_in;
  logic        user_valid;
  int          n_cmp = 0;
  int          n_bad = 0;
  opb_register_simulink2ppc_if bus ();
  opb_register_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .opb(bus),
    .user_data_in(user_data_in), .user_valid(user_valid)
  );
  always #5 clk = ~clk;
`ifdef OPB_S2P_OVERRUN_EN
  localparam logic [31:0] OV = 32'h2;
`else
  localparam logic [31:0] OV = 32'h0;
`endif
  localparam logic [31:0] D = 32'h01094200;
  localparam logic [31:0] S = 32'h01094204;
  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        cap;
    logic [31:0] cdata;
    logic        ack;
    logic [31:0] rdata;
  } vec_t;
  vec_t vec [23];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic capture(input logic [31:0] v);
    @(posedge clk); #1;
    user_valid = 1'b1; user_data_in = v;
    @(posedge clk); #1;
    user_valid = 1'b0;
  endtask
  task automatic xfer(input logic [31:0] a, input logic r, input logic [31:0] w, input logic [3:0] b,
                      output logic ack, output logic late, output logic [31:0] d);
    @(posedge clk); #1;
    bus.OPB_ABus = a; bus.OPB_RNW = r; bus.OPB_DBus = w; bus.OPB_BE = b; bus.OPB_select = 1'b1;
    @(posedge clk); #1;
    ack = bus.Sl_xferAck; d = bus.Sl_DBus;
    bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0;
    @(posedge clk); #1;
    late = bus.Sl_xferAck;
    @(posedge clk); #1;
    late |= bus.Sl_xferAck;
  endtask
  initial begin
    logic        ack, late;
    logic [31:0] d;
    int          acks;
    vec = '{
      '{S, 1, 0, 4'hF, 0, 0, 1, 32'h00000000},
      '{D, 1, 0, 4'hF, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF},
      '{S, 1, 0, 4'hF, 0, 0, 1, 32'h00010000},
      '{S, 1, 0, 4'hF, 1, 32'h1, 1, 32'h00020001},
      '{S, 1, 0, 4'hF, 1, 32'h2, 1, 32'h00030001 | OV},
      '{S, 0, 32'h2, 4'hF, 0, 0, 1, 32'h0},
      '{S, 1, 0, 4'hF, 0, 0, 1, 32'h00030001},
      '{D, 0, 32'h12345678, 4'hF, 0, 0, 1, 32'h0},
      '{D, 1, 0, 4'hF, 0, 0, 1, 32'h00000002},
      '{S, 1, 0, 4'hF, 0, 0, 1, 32'h00030000},
      '{32'h01094300, 1, 0, 4'hF, 0, 0, 0, 32'h0},
      '{32'h010941FC, 1, 0, 4'hF, 0, 0, 0, 32'h0},
      '{32'h010942FC, 1, 0, 4'hF, 0, 0, 1, 32'h00030000},
      '{S, 1, 0, 4'hF, 1, 32'h5, 1, 32'h00040001},
      '{S, 1, 0, 4'hF, 1, 32'h6, 1, 32'h00050001 | OV},
      '{S, 0, 32'h2, 4'b1110, 0, 0, 1, 32'h0},
      '{S, 1, 0, 4'hF, 0, 0, 1, 32'h00050001 | OV},
      '{S, 0, 32'hFFFFFFFD, 4'hF, 0, 0, 1, 32'h0},
      '{S, 1, 0, 4'hF, 0, 0, 1, 32'h00050001 | OV},
      '{S, 0, 32'h2, 4'b0001, 0, 0, 1, 32'h0},
      '{S, 1, 0, 4'hF, 0, 0, 1, 32'h00050001},
      '{D, 1, 0, 4'hF, 0, 0, 1, 32'h00000006},
      '{S, 1, 0, 4'hF, 1, 32'hAAAA, 1, 32'h00060001}
    };
    rst_n = 1'b0; user_valid = 1'b0; user_data_in = '0;
    bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
    bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
    chk("reset_dbus", bus.Sl_DBus, 32'h0);
    chk("reset_ties", {29'b0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < $size(vec); i++) begin
      if (vec[i].cap) capture(vec[i].cdata);
      xfer(vec[i].addr, vec[i].rnw, vec[i].wdata, vec[i].be, ack, late, d);
      chk($sformatf("v%0d_ack", i), {30'b0, ack, late}, {30'b0, vec[i].ack, 1'b0});
      chk($sformatf("v%0d_dbus", i), d, vec[i].rdata);
    end
    // DATA read with a capture landing in its ACK cycle
    @(posedge clk); #1;
    bus.OPB_ABus = D; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    @(posedge clk); #1;
    chk("race_ack", {31'b0, bus.Sl_xferAck}, 32'h1);
    chk("race_old_data", bus.Sl_DBus, 32'h0000AAAA);
    user_valid = 1'b1; user_data_in = 32'h0000BBBB;
    bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0;
    @(posedge clk); #1;
    user_valid = 1'b0;
    @(posedge clk);
    xfer(S, 1'b1, 32'h0, 4'hF, ack, late, d);
    chk("race_status", d, 32'h00070001);
    xfer(D, 1'b1, 32'h0, 4'hF, ack, late, d);
    chk("race_new_data", d, 32'h0000BBBB);
    acks = 0;
    @(posedge clk); #1;
    bus.OPB_ABus = S; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      acks += int'(bus.Sl_xferAck);
    end
    bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0;
    repeat (2) @(posedge clk);
    chk("hold_one_ack", acks, 32'd1);
    @(posedge clk); #1;
    bus.OPB_ABus = D; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    rst_n = 1'b0; user_valid = 1'b1; user_data_in = 32'h55;
    @(posedge clk); #1;
    chk("rst_mid_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
    chk("rst_mid_dbus", bus.Sl_DBus, 32'h0);
    bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; user_valid = 1'b0;
    chk("rst_after_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
    xfer(D, 1'b1, 32'h0, 4'hF, ack, late, d);
    chk("rst_data_clear", d, 32'h0);
    xfer(S, 1'b1, 32'h0, 4'hF, ack, late, d);
    chk("rst_status_clear", d, 32'h0);
    @(posedge clk); #1;
    user_valid = 1'b1; user_data_in = 32'h77;
    repeat (65536) @(posedge clk);
    #1;
    user_valid = 1'b0;
    xfer(S, 1'b1, 32'h0, 4'hF, ack, late, d);
    chk("wrap_status", d, 32'h00000001 | OV);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
